// File: rtl/ahb2mem_wr_drain.sv
// rtl/ahb2mem_wr_drain.sv - drains packed write entries from a FWFT FIFO into single-beat memory writes
//
// Purpose: pops {be, addr, data} entries from the write FIFO head and replays
// each as one write on a ready-handshaked SRAM-style port. Sustains one write
// per cycle against a zero-wait memory.
//
// Optional feature: define AHB2MEM_DRAIN_TIMEOUT_EN to abort a write that has
// waited TMO_CYC cycles, discarding the entry and raising sticky o_err.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_fifo_empty         FIFO empty flag
//   i_fifo_dout          FIFO head entry {be, addr, data}, data in the LSBs
//   o_fifo_rd            pop strobe (combinational)
//   o_mem_cs, o_mem_we   write request valid / write enable
//   o_mem_addr           write byte address
//   o_mem_wdata          write data
//   o_mem_be             byte enables
//   i_mem_ready          memory accepts the request this cycle
//   o_wr_done            one-cycle pulse per accepted write
//   o_err                sticky timeout error (0 when timeout feature is off)
//   i_err_clr            clears o_err
//   o_idle               IDLE and FIFO empty
module ahb2mem_wr_drain #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TMO_CYC = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_fifo_empty,
  input  logic [DWIDTH/8+AWIDTH+DWIDTH-1:0]  i_fifo_dout,
  output logic                               o_fifo_rd,
  output logic                               o_mem_cs,
  output logic                               o_mem_we,
  output logic [AWIDTH-1:0]                  o_mem_addr,
  output logic [DWIDTH-1:0]                  o_mem_wdata,
  output logic [DWIDTH/8-1:0]                o_mem_be,
  input  logic                               i_mem_ready,
  output logic                               o_wr_done,
  output logic                               o_err,
  input  logic                               i_err_clr,
  output logic                               o_idle
);

  localparam int BEW = DWIDTH / 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_abort;
  logic                w_pop;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [BEW-1:0]      r_be;
  logic                r_wr_done;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pop decision. A pop always (re)enters REQ, which also
  // covers the back-to-back case where an accept and a pop coincide.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pop       = 1'b0;
    if (r_state == S_REQ) begin
      w_accept = i_mem_ready;
    end
    w_pop = !i_fifo_empty && ((r_state == S_IDLE) || w_accept || w_abort);
    if (w_pop) begin
      w_state_nxt = S_REQ;
    end else if (w_accept || w_abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Captured request; held across wait states and kept (not zeroed) in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= w_accept;
      if (w_pop) begin
        {r_be, r_addr, r_wdata} <= i_fifo_dout;
      end
    end
  end

`ifdef AHB2MEM_DRAIN_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  logic [7:0] r_wait_cnt;
  logic       r_err;

  // Abort on the last allowed wait cycle; a ready in that cycle still wins.
  assign w_abort = (r_state == S_REQ) && !i_mem_ready && (r_wait_cnt == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_wait_cnt <= 8'd0;
      end else if ((r_state == S_REQ) && !i_mem_ready && (r_wait_cnt != 8'hFF)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      // Set has priority over clear when both happen in one cycle.
      if (w_abort) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_err_clr;

  assign w_abort          = 1'b0;
  assign o_err            = 1'b0;
  assign w_unused_err_clr = i_err_clr;
`endif

  assign o_fifo_rd   = w_pop;
  assign o_mem_cs    = (r_state == S_REQ);
  assign o_mem_we    = (r_state == S_REQ);
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_be    = r_be;
  assign o_wr_done   = r_wr_done;
  assign o_idle      = (r_state == S_IDLE) && i_fifo_empty;

endmodule

// File: tb/tb_ahb2mem_wr_drain.sv
// tb/tb_ahb2mem_wr_drain.sv - self-checking bench for ahb2mem_wr_drain
module tb_ahb2mem_wr_drain;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 4;

  typedef struct packed {
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_fifo_empty;
  ent_t           i_fifo_dout;
  logic           o_fifo_rd;
  logic           o_mem_cs;
  logic           o_mem_we;
  logic [AW-1:0]  o_mem_addr;
  logic [DW-1:0]  o_mem_wdata;
  logic [BW-1:0]  o_mem_be;
  logic           i_mem_ready;
  logic           o_wr_done;
  logic           o_err;
  logic           i_err_clr;
  logic           o_idle;

  always #5 clk = ~clk;

  ahb2mem_wr_drain #(.AWIDTH(AW), .DWIDTH(DW), .TMO_CYC(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_dout (i_fifo_dout),
    .o_fifo_rd   (o_fifo_rd),
    .o_mem_cs    (o_mem_cs),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_be    (o_mem_be),
    .i_mem_ready (i_mem_ready),
    .o_wr_done   (o_wr_done),
    .o_err       (o_err),
    .i_err_clr   (i_err_clr),
    .o_idle      (o_idle)
  );

  // FIFO contents, everything ever pushed, model-accepted writes, DUT-observed writes
  ent_t tbq[$];
  ent_t pushed[$];
  ent_t m_written[$];
  ent_t dut_wr[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cs_cycles = 0;
  int done_pulses = 0;

  // Reference model: one outstanding write slot plus its wait time
  bit   m_busy;
  ent_t m_cur;
  bit   m_done;
  bit   m_err;
  int   m_wait;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_cur  = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_wait = 0;
  endtask

  task automatic push(input ent_t e);
    tbq.push_back(e);
    pushed.push_back(e);
  endtask

  function automatic ent_t mk(input logic [BW-1:0] be, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ent_t e;
    e.be = be; e.addr = a; e.data = d;
    return e;
  endfunction

  // One clock cycle: drive at negedge, check outputs, advance model at posedge.
  task automatic step(input bit rdy, input bit clr);
    bit   emp, acc, abt, pop;
    ent_t head;
    emp = (tbq.size() == 0);
    if (!emp) head = tbq[0];
    else head = mk(BW'($urandom), $urandom, $urandom);
    i_mem_ready  = rdy;
    i_err_clr    = clr;
    i_fifo_empty = emp;
    i_fifo_dout  = head;
    acc = m_busy && rdy;
    abt = 1'b0;
`ifdef AHB2MEM_DRAIN_TIMEOUT_EN
    abt = m_busy && !rdy && (m_wait == TMO - 1);
`endif
    pop = !emp && (!m_busy || acc || abt);
    #1;
    chk("mem_cs",    o_mem_cs,    m_busy);
    chk("mem_we",    o_mem_we,    m_busy);
    chk("mem_addr",  o_mem_addr,  m_cur.addr);
    chk("mem_wdata", o_mem_wdata, m_cur.data);
    chk("mem_be",    o_mem_be,    m_cur.be);
    chk("fifo_rd",   o_fifo_rd,   pop);
    chk("wr_done",   o_wr_done,   m_done);
    chk("err",       o_err,       m_err);
    chk("idle",      o_idle,      !m_busy && emp);
    if (o_mem_cs) cs_cycles++;
    if (o_wr_done) done_pulses++;
    if (o_mem_cs && rdy) dut_wr.push_back(mk(o_mem_be, o_mem_addr, o_mem_wdata));
    @(posedge clk);
    if (acc) m_written.push_back(m_cur);
    m_done = acc;
    if (abt) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (pop) begin
      m_cur  = tbq.pop_front();
      m_busy = 1'b1;
      m_wait = 0;
    end else if (acc || abt) begin
      m_busy = 1'b0;
    end else if (m_busy && m_wait < 255) begin
      m_wait++;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, c0, d0, guard, n;
    rst_n        = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_dout  = '0;
    i_mem_ready  = 1'b0;
    i_err_clr    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cs",    o_mem_cs,    1'b0);
    chk("rst_addr",  o_mem_addr,  32'h0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    chk("rst_be",    o_mem_be,    4'h0);
    chk("rst_done",  o_wr_done,   1'b0);
    chk("rst_err",   o_err,       1'b0);
    chk("rst_rd",    o_fifo_rd,   1'b0);
    rst_n = 1'b1;

    // Single write
    push(mk(4'hF, 32'h0000_0100, 32'hDEAD_BEEF));
    step(1'b1, 1'b0);
    chk("single_cs",   o_mem_cs,    1'b1);
    chk("single_addr", o_mem_addr,  32'h0000_0100);
    chk("single_data", o_mem_wdata, 32'hDEAD_BEEF);
    chk("single_be",   o_mem_be,    4'hF);
    step(1'b1, 1'b0);
    chk("single_cs_low", o_mem_cs,  1'b0);
    chk("single_done",   o_wr_done, 1'b1);
    step(1'b1, 1'b0);
    chk("single_done_off", o_wr_done, 1'b0);
    chk("single_idle",     o_idle,    1'b1);

    // Zero-wait burst of four
    base = dut_wr.size();
    c0 = cs_cycles;
    d0 = done_pulses;
    for (int i = 0; i < 4; i++) push(mk(4'hF, 32'(i * 4), 32'(8'h11 * (i + 1))));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("burst_cs_cycles", cs_cycles - c0, 4);
    chk("burst_done",      done_pulses - d0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_addr", dut_wr[base + i].addr, 32'(i * 4));
      chk("burst_data", dut_wr[base + i].data, 32'(8'h11 * (i + 1)));
    end

    // Three wait states then accept; next entry popped only in accept cycle
    push(mk(4'h3, 32'h200, 32'hA5A5_0001));
    push(mk(4'hC, 32'h204, 32'hA5A5_0002));
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("wait_q_left", tbq.size(), 1);
    chk("wait_addr",   o_mem_addr, 32'h200);
    step(1'b1, 1'b0);
    chk("wait_q_left2", tbq.size(), 0);
    chk("wait_addr2",   o_mem_addr, 32'h204);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

`ifdef AHB2MEM_DRAIN_TIMEOUT_EN
    // Timeout: four REQ cycles with ready low abort the first entry
    push(mk(4'hF, 32'h300, 32'h1111_0000));
    push(mk(4'hF, 32'h304, 32'h2222_0000));
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("tmo_err",  o_err,      1'b1);
    chk("tmo_done", o_wr_done,  1'b0);
    chk("tmo_next", o_mem_addr, 32'h304);
    step(1'b1, 1'b1);
    chk("tmo_clr",  o_err,      1'b0);
    chk("tmo_done2", o_wr_done, 1'b1);
    step(1'b1, 1'b0);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 40 && tbq.size() < 8)
        push(mk(BW'($urandom), $urandom, $urandom));
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
    end
    guard = 0;
    while ((tbq.size() > 0 || m_busy) && guard < 100) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("drain_bound", guard < 100, 1'b1);

    // Scoreboard: DUT writes in order versus model-accepted writes
    chk("sb_count", dut_wr.size(), m_written.size());
    n = (dut_wr.size() < m_written.size()) ? dut_wr.size() : m_written.size();
    for (int i = 0; i < n; i++) chk("sb_entry", dut_wr[i], m_written[i]);
`ifndef AHB2MEM_DRAIN_TIMEOUT_EN
    chk("sb_all_written", m_written.size(), pushed.size());
    n = (m_written.size() < pushed.size()) ? m_written.size() : pushed.size();
    for (int i = 0; i < n; i++) chk("sb_pushed", m_written[i], pushed[i]);
`endif

    // Reset while a request is outstanding
    push(mk(4'h5, 32'hABC0, 32'h1234_5678));
    step(1'b0, 1'b0);
    chk("rmid_cs_before", o_mem_cs, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_cs",    o_mem_cs,    1'b0);
    chk("rmid_we",    o_mem_we,    1'b0);
    chk("rmid_addr",  o_mem_addr,  32'h0);
    chk("rmid_wdata", o_mem_wdata, 32'h0);
    chk("rmid_be",    o_mem_be,    4'h0);
    chk("rmid_done",  o_wr_done,   1'b0);
    chk("rmid_err",   o_err,       1'b0);
    @(negedge clk);
    chk("rmid_no_done", o_wr_done, 1'b0);
    rst_n = 1'b1;
    model_reset();
    tbq.delete();

    // Empty FIFO with ready high
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      chk("empty_idle", o_idle, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
